// File: rtl/sid_host_reg_if.sv
// ============================================================================
// Module  : sid_host_reg_if
// Purpose : Host write port for the SID register bank. It synchronises the
//           write strobe, decodes voice/address and holds all registers.
// Option  : SID_REG_READBACK_EN enables registered byte readback on uio.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sid_host_reg_if #(
  parameter int NUM_VOICES  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [7:0]              ui_in,
  input  logic [7:0]              uio_in,
  output logic [7:0]              uio_out,
  output logic [7:0]              uio_oe,
  output logic [NUM_VOICES*16-1:0] freq_o,
  output logic [NUM_VOICES*12-1:0] pw_o,
  output logic [NUM_VOICES*4-1:0] attack_o,
  output logic [NUM_VOICES*4-1:0] decay_o,
  output logic [NUM_VOICES*4-1:0] sustain_o,
  output logic [NUM_VOICES*4-1:0] release_o,
  output logic [NUM_VOICES*8-1:0] wave_ctrl_o,
  output logic [10:0]             fc_o,
  output logic [3:0]              res_o,
  output logic [3:0]              filt_en_o,
  output logic [3:0]              mode_o,
  output logic [3:0]              vol_o,
  output logic                    wr_pulse_o,
  output logic [1:0]              wr_voice_o,
  output logic [2:0]              wr_addr_o
);

  localparam logic [1:0] C_FILTER_VOICE = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_edge;
  logic [1:0]             w_voice;
  logic [2:0]             w_addr;
  logic                   w_unused;

  logic [15:0] r_freq    [NUM_VOICES];
  logic [11:0] r_pw      [NUM_VOICES];
  logic [3:0]  r_attack  [NUM_VOICES];
  logic [3:0]  r_decay   [NUM_VOICES];
  logic [3:0]  r_sustain [NUM_VOICES];
  logic [3:0]  r_release [NUM_VOICES];
  logic [7:0]  r_wave    [NUM_VOICES];
  logic [10:0] r_fc;
  logic [3:0]  r_res;
  logic [3:0]  r_filt_en;
  logic [3:0]  r_mode;
  logic [3:0]  r_vol;
  logic        r_wr_pulse;
  logic [1:0]  r_wr_voice;
  logic [2:0]  r_wr_addr;

  assign w_voice  = ui_in[4:3];
  assign w_addr   = ui_in[2:0];
  assign w_unused = &{1'b0, ui_in[6:5]};

  // Edge is qualified by ena at detection time; the history flop still
  // advances when ena is low, so a masked edge is consumed.
  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist & ena;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ui_in[7]};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_freq[v]    <= '0;
        r_pw[v]      <= '0;
        r_attack[v]  <= '0;
        r_decay[v]   <= '0;
        r_sustain[v] <= '0;
        r_release[v] <= '0;
        r_wave[v]    <= '0;
      end
      r_fc       <= '0;
      r_res      <= '0;
      r_filt_en  <= '0;
      r_mode     <= '0;
      r_vol      <= '0;
      r_wr_pulse <= 1'b0;
      r_wr_voice <= '0;
      r_wr_addr  <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_edge) begin
        r_wr_pulse <= 1'b1;
        r_wr_voice <= w_voice;
        r_wr_addr  <= w_addr;
        if (w_voice == C_FILTER_VOICE) begin
          case (w_addr)
            3'd0:    r_fc[2:0]  <= uio_in[2:0];
            3'd1:    r_fc[10:3] <= uio_in;
            3'd2:    {r_res, r_filt_en} <= uio_in;
            3'd3:    {r_mode, r_vol}    <= uio_in;
            default: ;
          endcase
        end else begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_voice == 2'(v)) begin
              case (w_addr)
                3'd0:    r_freq[v][7:0]  <= uio_in;
                3'd1:    r_freq[v][15:8] <= uio_in;
                3'd2:    r_pw[v][7:0]    <= uio_in;
                3'd3:    r_pw[v][11:8]   <= uio_in[3:0];
                3'd4:    {r_decay[v], r_attack[v]}    <= uio_in;
                3'd5:    {r_release[v], r_sustain[v]} <= uio_in;
                3'd6:    r_wave[v] <= uio_in;
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  generate
    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice_out
      assign freq_o[gv*16 +: 16]     = r_freq[gv];
      assign pw_o[gv*12 +: 12]       = r_pw[gv];
      assign attack_o[gv*4 +: 4]     = r_attack[gv];
      assign decay_o[gv*4 +: 4]      = r_decay[gv];
      assign sustain_o[gv*4 +: 4]    = r_sustain[gv];
      assign release_o[gv*4 +: 4]    = r_release[gv];
      assign wave_ctrl_o[gv*8 +: 8]  = r_wave[gv];
    end
  endgenerate

  assign fc_o       = r_fc;
  assign res_o      = r_res;
  assign filt_en_o  = r_filt_en;
  assign mode_o     = r_mode;
  assign vol_o      = r_vol;
  assign wr_pulse_o = r_wr_pulse;
  assign wr_voice_o = r_wr_voice;
  assign wr_addr_o  = r_wr_addr;

`ifdef SID_REG_READBACK_EN
  logic [7:0] w_rd_byte;
  logic [7:0] r_rd_data;
  logic       r_rd_oe;

  // Readback mirrors the write packing; unused bits come back as zero.
  always_comb begin
    w_rd_byte = '0;
    if (w_voice == C_FILTER_VOICE) begin
      case (w_addr)
        3'd0:    w_rd_byte = {5'd0, r_fc[2:0]};
        3'd1:    w_rd_byte = r_fc[10:3];
        3'd2:    w_rd_byte = {r_res, r_filt_en};
        3'd3:    w_rd_byte = {r_mode, r_vol};
        default: w_rd_byte = '0;
      endcase
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_voice == 2'(v)) begin
          case (w_addr)
            3'd0:    w_rd_byte = r_freq[v][7:0];
            3'd1:    w_rd_byte = r_freq[v][15:8];
            3'd2:    w_rd_byte = r_pw[v][7:0];
            3'd3:    w_rd_byte = {4'd0, r_pw[v][11:8]};
            3'd4:    w_rd_byte = {r_decay[v], r_attack[v]};
            3'd5:    w_rd_byte = {r_release[v], r_sustain[v]};
            3'd6:    w_rd_byte = r_wave[v];
            default: w_rd_byte = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_oe   <= 1'b0;
    end else begin
      r_rd_oe   <= ui_in[6];
      r_rd_data <= ui_in[6] ? w_rd_byte : 8'd0;
    end
  end

  assign uio_out = r_rd_data;
  assign uio_oe  = {8{r_rd_oe}};
`else
  assign uio_out = 8'd0;
  assign uio_oe  = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sid_host_reg_if.sv
// ============================================================================
// Module  : tb_sid_host_reg_if
// Purpose : Randomised self-checking bench for sid_host_reg_if against a
//           byte-image register model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sid_host_reg_if;

  localparam int NV = 3;
  localparam int SS = 2;

  logic                clk;
  logic                rst_n;
  logic                ena;
  logic [7:0]          ui_in;
  logic [7:0]          uio_in;
  logic [7:0]          uio_out;
  logic [7:0]          uio_oe;
  logic [NV*16-1:0]    freq_o;
  logic [NV*12-1:0]    pw_o;
  logic [NV*4-1:0]     attack_o;
  logic [NV*4-1:0]     decay_o;
  logic [NV*4-1:0]     sustain_o;
  logic [NV*4-1:0]     release_o;
  logic [NV*8-1:0]     wave_ctrl_o;
  logic [10:0]         fc_o;
  logic [3:0]          res_o;
  logic [3:0]          filt_en_o;
  logic [3:0]          mode_o;
  logic [3:0]          vol_o;
  logic                wr_pulse_o;
  logic [1:0]          wr_voice_o;
  logic [2:0]          wr_addr_o;

  int n_cmp;
  int n_err;

  // Model: one byte per {voice, addr} holding what a host readback would see.
  logic [7:0] bank [4][8];
  logic [1:0] exp_voice;
  logic [2:0] exp_addr;

  sid_host_reg_if #(.NUM_VOICES(NV), .SYNC_STAGES(SS)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .ui_in       (ui_in),
    .uio_in      (uio_in),
    .uio_out     (uio_out),
    .uio_oe      (uio_oe),
    .freq_o      (freq_o),
    .pw_o        (pw_o),
    .attack_o    (attack_o),
    .decay_o     (decay_o),
    .sustain_o   (sustain_o),
    .release_o   (release_o),
    .wave_ctrl_o (wave_ctrl_o),
    .fc_o        (fc_o),
    .res_o       (res_o),
    .filt_en_o   (filt_en_o),
    .mode_o      (mode_o),
    .vol_o       (vol_o),
    .wr_pulse_o  (wr_pulse_o),
    .wr_voice_o  (wr_voice_o),
    .wr_addr_o   (wr_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++)
      for (int a = 0; a < 8; a++)
        bank[v][a] = 8'd0;
    exp_voice = 2'd0;
    exp_addr  = 3'd0;
  endtask

  task automatic model_write(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d);
    exp_voice = v;
    exp_addr  = a;
    if (v == 2'd3) begin
      if (a == 3'd0)      bank[3][0] = d & 8'h07;
      else if (a < 3'd4)  bank[3][a] = d;
    end else if (int'(v) < NV && a != 3'd7) begin
      bank[v][a] = (a == 3'd3) ? (d & 8'h0F) : d;
    end
  endtask

  task automatic check_all();
    logic [63:0] e_freq, e_pw, e_att, e_dec, e_sus, e_rel, e_wave;
    e_freq = '0; e_pw = '0; e_att = '0; e_dec = '0; e_sus = '0; e_rel = '0; e_wave = '0;
    for (int v = 0; v < NV; v++) begin
      e_freq[v*16 +: 16] = {bank[v][1], bank[v][0]};
      e_pw[v*12 +: 12]   = {bank[v][3][3:0], bank[v][2]};
      e_att[v*4 +: 4]    = bank[v][4][3:0];
      e_dec[v*4 +: 4]    = bank[v][4][7:4];
      e_sus[v*4 +: 4]    = bank[v][5][3:0];
      e_rel[v*4 +: 4]    = bank[v][5][7:4];
      e_wave[v*8 +: 8]   = bank[v][6];
    end
    check_eq("freq",    64'(freq_o),      e_freq);
    check_eq("pw",      64'(pw_o),        e_pw);
    check_eq("attack",  64'(attack_o),    e_att);
    check_eq("decay",   64'(decay_o),     e_dec);
    check_eq("sustain", 64'(sustain_o),   e_sus);
    check_eq("release", 64'(release_o),   e_rel);
    check_eq("wave",    64'(wave_ctrl_o), e_wave);
    check_eq("fc",      64'(fc_o),        64'({bank[3][1], bank[3][0][2:0]}));
    check_eq("res",     64'(res_o),       64'(bank[3][2][7:4]));
    check_eq("filt_en", 64'(filt_en_o),   64'(bank[3][2][3:0]));
    check_eq("mode",    64'(mode_o),      64'(bank[3][3][7:4]));
    check_eq("vol",     64'(vol_o),       64'(bank[3][3][3:0]));
    check_eq("wr_voice", 64'(wr_voice_o), 64'(exp_voice));
    check_eq("wr_addr",  64'(wr_addr_o),  64'(exp_addr));
    check_eq("uio_oe_idle", 64'(uio_oe),  64'd0);
  endtask

  // Strobe-driven write; pulse must appear only right after posedge SS.
  task automatic do_write(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d,
                          input logic en);
    int pulses;
    int hold;
    @(negedge clk);
    ena    = en;
    ui_in  = {3'b000, v, a};
    uio_in = d;
    @(negedge clk);
    ui_in[7] = 1'b1;
    hold   = SS + 2 + int'($urandom_range(0, 2));
    pulses = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (wr_pulse_o) pulses++;
      check_eq("pulse_timing", 64'(wr_pulse_o), 64'((k == SS) && en));
    end
    @(negedge clk);
    ui_in[7] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (wr_pulse_o) pulses++;
    end
    check_eq("pulse_count", 64'(pulses), en ? 64'd1 : 64'd0);
    ena = 1'b1;
    if (en) model_write(v, a, d);
    check_all();
  endtask

  task automatic do_read(input logic [1:0] v, input logic [2:0] a);
    @(negedge clk);
    ui_in = {3'b010, v, a};
    @(posedge clk); #1;
`ifdef SID_REG_READBACK_EN
    check_eq("rd_oe",   64'(uio_oe),  64'hFF);
    check_eq("rd_data", 64'(uio_out), 64'(bank[v][a]));
`else
    check_eq("rd_oe",   64'(uio_oe),  64'h00);
    check_eq("rd_data", 64'(uio_out), 64'h00);
`endif
    @(negedge clk);
    ui_in = 8'd0;
    @(posedge clk); #1;
    check_eq("rd_oe_off", 64'(uio_oe), 64'h00);
  endtask

  initial begin
    int pulses;
    logic [1:0] rv;
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;

    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (wr_pulse_o) pulses++;
    end
    check_eq("idle_pulses", 64'(pulses), 64'd0);
    check_eq("uio_out_rst", 64'(uio_out), 64'd0);
    check_all();

    do_write(2'd0, 3'd0, 8'h1D, 1'b1);
    do_write(2'd0, 3'd1, 8'h00, 1'b1);
    check_eq("freq0", 64'(freq_o[15:0]), 64'h001D);
    do_write(2'd0, 3'd4, 8'h7B, 1'b1);
    do_write(2'd0, 3'd5, 8'hB8, 1'b1);
    check_eq("attack0", 64'(attack_o[3:0]), 64'd11);
    check_eq("release0", 64'(release_o[3:0]), 64'd11);
    do_write(2'd0, 3'd6, 8'h21, 1'b1);
    check_eq("gate_on", 64'(wave_ctrl_o[0]), 64'd1);
    do_write(2'd0, 3'd6, 8'h20, 1'b1);
    check_eq("gate_off", 64'(wave_ctrl_o[0]), 64'd0);
    check_eq("wave_b5", 64'(wave_ctrl_o[5]), 64'd1);
    do_write(2'd3, 3'd3, 8'h0F, 1'b1);
    check_eq("vol", 64'(vol_o), 64'd15);
    do_write(2'd3, 3'd6, 8'hAA, 1'b1);
    do_write(2'd0, 3'd7, 8'h55, 1'b1);
    do_write(2'd1, 3'd0, 8'h99, 1'b0);
    do_read(2'd0, 3'd4);
    do_read(2'd3, 3'd3);

    // Strobe rises, reset lands before the write, strobe held through release.
    @(negedge clk);
    ui_in  = {3'b100, 2'd2, 3'd2};
    uio_in = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    model_reset();
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < SS + 4; k++) begin
      @(posedge clk); #1;
      if (wr_pulse_o) pulses++;
      check_eq("rst_pulse_timing", 64'(wr_pulse_o), 64'(k == SS));
    end
    @(negedge clk);
    ui_in[7] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pulse_count", 64'(pulses), 64'd1);
    model_write(2'd2, 3'd2, 8'h5A);
    check_all();

    for (int i = 0; i < 40; i++) begin
      rv = 2'($urandom_range(0, 3));
      do_write(rv, 3'($urandom_range(0, 7)), 8'($urandom), ($urandom_range(0, 7) != 0));
      if (i % 8 == 0) do_read(rv, 3'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got stuck expected done");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
